alarm_clock_controller: RTL and testbench

Central sequencer for the alarm clock datapath. It drives the enable, count-down and load controls of five modulo counters: time seconds, minutes and hours, plus alarm minutes and hours. It runs the timekeeping cascade from a 1 Hz tick, handles the user set-mode state machine, and detects and times out the alarm. It sits between the debounced button and tick sources and the counter bank; display logic reads its status outputs.

---
 rtl/alarm_clock_controller.sv | 196 +++++++++++++++++++
 tb/tb_alarm_clock_controller.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alarm_clock_controller.sv
// alarm_clock_controller: 1 Hz cascade, set-mode FSM and alarm ring/timeout sequencer.
// Rev 1.0
`default_nettype none

module alarm_clock_controller #(
  parameter int SEC_MOD      = 60,
  parameter int MIN_MOD      = 60,
  parameter int HR_MOD       = 24,
  parameter int RING_SECONDS = 60
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       tick_1hz_i,
  input  logic       btn_mode_i,
  input  logic       btn_left_i,
  input  logic       btn_right_i,
  input  logic       btn_up_i,
  input  logic       btn_down_i,
  input  logic       alarm_on_i,
  input  logic [5:0] sec_count_i,
  input  logic [5:0] min_count_i,
  input  logic [5:0] alarm_min_count_i,
  input  logic [4:0] hr_count_i,
  input  logic [4:0] alarm_hr_count_i,
  output logic       sec_en_o,
  output logic       min_en_o,
  output logic       hr_en_o,
  output logic       min_dn_o,
  output logic       hr_dn_o,
  output logic       sec_load_o,
  output logic       alarm_min_en_o,
  output logic       alarm_hr_en_o,
  output logic       alarm_min_dn_o,
  output logic       alarm_hr_dn_o,
  output logic       setting_o,
  output logic [1:0] sel_field_o,
  output logic       blink_o,
  output logic       ringing_o
);

  localparam int         RW       = $clog2(RING_SECONDS + 1);
  localparam logic [5:0] SEC_LAST = 6'(SEC_MOD - 1);
  localparam logic [5:0] MIN_LAST = 6'(MIN_MOD - 1);

  // Moduli must fit the counter port widths.
  if (SEC_MOD < 2 || SEC_MOD > 64 || MIN_MOD < 2 || MIN_MOD > 64 ||
      HR_MOD < 2 || HR_MOD > 32 || RING_SECONDS < 1) begin : g_bad_params
    $error("alarm_clock_controller: parameter out of range");
  end

  typedef enum logic [2:0] {
    RUN           = 3'd0,
    SET_TIME_HR   = 3'd1,
    SET_TIME_MIN  = 3'd2,
    SET_ALARM_HR  = 3'd3,
    SET_ALARM_MIN = 3'd4
  } state_t;

  state_t          state_q;
  logic [1:0]      sel_q;
  logic            setting_q, blink_q, ringing_q, match_q;
  logic [RW-1:0]   ring_cnt_q;
  logic            sec_en_q, min_en_q, hr_en_q, min_dn_q, hr_dn_q, sec_load_q;
  logic            amin_en_q, ahr_en_q, amin_dn_q, ahr_dn_q;

  logic [1:0]      sel_next_d, sel_prev_d;
  logic            w_match, w_any_btn, w_btn_act, w_in_set, w_sec_last, w_min_last;

  assign sel_next_d = sel_q + 2'd1;
  assign sel_prev_d = sel_q - 2'd1;
  assign w_in_set   = (state_q != RUN);
  assign w_sec_last = (sec_count_i == SEC_LAST);
  assign w_min_last = (min_count_i == MIN_LAST);
  assign w_match    = !w_in_set && alarm_on_i && (sec_count_i == 6'd0) &&
                      (min_count_i == alarm_min_count_i) && (hr_count_i == alarm_hr_count_i);
  assign w_any_btn  = btn_mode_i | btn_left_i | btn_right_i | btn_up_i | btn_down_i;
  // A button pressed while ringing only dismisses the alarm.
  assign w_btn_act  = ~(ringing_q & w_any_btn);

  function automatic state_t field_state(input logic [1:0] f);
    case (f)
      2'd0:    field_state = SET_TIME_HR;
      2'd1:    field_state = SET_TIME_MIN;
      2'd2:    field_state = SET_ALARM_HR;
      default: field_state = SET_ALARM_MIN;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= RUN;
      sel_q      <= 2'd0;
      setting_q  <= 1'b0;
      blink_q    <= 1'b0;
      ringing_q  <= 1'b0;
      match_q    <= 1'b0;
      ring_cnt_q <= '0;
      sec_en_q   <= 1'b0;
      min_en_q   <= 1'b0;
      hr_en_q    <= 1'b0;
      min_dn_q   <= 1'b0;
      hr_dn_q    <= 1'b0;
      sec_load_q <= 1'b0;
      amin_en_q  <= 1'b0;
      ahr_en_q   <= 1'b0;
      amin_dn_q  <= 1'b0;
      ahr_dn_q   <= 1'b0;
    end else begin
      sec_en_q   <= 1'b0;
      min_en_q   <= 1'b0;
      hr_en_q    <= 1'b0;
      min_dn_q   <= 1'b0;
      hr_dn_q    <= 1'b0;
      sec_load_q <= 1'b0;
      amin_en_q  <= 1'b0;
      ahr_en_q   <= 1'b0;
      amin_dn_q  <= 1'b0;
      ahr_dn_q   <= 1'b0;
      match_q    <= w_match;

      if (ringing_q) begin
        if (!alarm_on_i || w_any_btn) begin
          ringing_q  <= 1'b0;
          ring_cnt_q <= '0;
        end else if (tick_1hz_i) begin
          if (ring_cnt_q == RW'(RING_SECONDS - 1)) begin
            ringing_q  <= 1'b0;
            ring_cnt_q <= '0;
          end else begin
            ring_cnt_q <= ring_cnt_q + 1'b1;
          end
        end
      end else if (w_match && !match_q) begin
        ringing_q  <= 1'b1;
        ring_cnt_q <= '0;
      end

      if (!w_in_set && tick_1hz_i) begin
        sec_en_q <= 1'b1;
        min_en_q <= w_sec_last;
        hr_en_q  <= w_sec_last && w_min_last;
      end

      if (w_in_set && tick_1hz_i) begin
        blink_q <= ~blink_q;
      end

      if (w_btn_act) begin
        if (btn_mode_i) begin
          sel_q   <= 2'd0;
          blink_q <= 1'b0;
          if (w_in_set) begin
            state_q    <= RUN;
            setting_q  <= 1'b0;
            sec_load_q <= 1'b1;
          end else begin
            state_q   <= SET_TIME_HR;
            setting_q <= 1'b1;
          end
        end else if (w_in_set) begin
          if (btn_left_i || btn_right_i) begin
            if (btn_left_i ^ btn_right_i) begin
              sel_q   <= btn_left_i ? sel_prev_d : sel_next_d;
              state_q <= field_state(btn_left_i ? sel_prev_d : sel_next_d);
            end
          end else if (btn_up_i ^ btn_down_i) begin
            case (sel_q)
              2'd0: begin hr_en_q   <= btn_up_i; hr_dn_q   <= btn_down_i; end
              2'd1: begin min_en_q  <= btn_up_i; min_dn_q  <= btn_down_i; end
              2'd2: begin ahr_en_q  <= btn_up_i; ahr_dn_q  <= btn_down_i; end
              default: begin amin_en_q <= btn_up_i; amin_dn_q <= btn_down_i; end
            endcase
          end
        end
      end
    end
  end

  assign sec_en_o       = sec_en_q;
  assign min_en_o       = min_en_q;
  assign hr_en_o        = hr_en_q;
  assign min_dn_o       = min_dn_q;
  assign hr_dn_o        = hr_dn_q;
  assign sec_load_o     = sec_load_q;
  assign alarm_min_en_o = amin_en_q;
  assign alarm_hr_en_o  = ahr_en_q;
  assign alarm_min_dn_o = amin_dn_q;
  assign alarm_hr_dn_o  = ahr_dn_q;
  assign setting_o      = setting_q;
  assign sel_field_o    = sel_q;
  assign blink_o        = blink_q;
  assign ringing_o      = ringing_q;

endmodule

`default_nettype wire

// File: tb/tb_alarm_clock_controller.sv
// tb_alarm_clock_controller: directed scoreboard bench for alarm_clock_controller.
// Rev 1.0
`default_nettype none

module tb_alarm_clock_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       btn_mode = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic       alarm_on = 1'b0;
  logic [5:0] sec_count = 6'd0, min_count = 6'd0, alarm_min_count = 6'd0;
  logic [4:0] hr_count = 5'd0, alarm_hr_count = 5'd0;

  logic sec_en, min_en, hr_en, min_dn, hr_dn, sec_load;
  logic alarm_min_en, alarm_hr_en, alarm_min_dn, alarm_hr_dn;
  logic setting, blink, ringing;
  logic [1:0] sel_field;
  logic [14:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  logic [14:0] exp_q[$];
  string       tag_q[$];

  localparam logic [14:0] E_SEC   = 15'h4000, E_MIN  = 15'h2000, E_HR   = 15'h1000;
  localparam logic [14:0] E_MDN   = 15'h0800, E_HDN  = 15'h0400, E_LOAD = 15'h0200;
  localparam logic [14:0] E_AMEN  = 15'h0100, E_AHEN = 15'h0080, E_AMDN = 15'h0040;
  localparam logic [14:0] E_AHDN  = 15'h0020, E_SET  = 15'h0010, E_BLINK = 15'h0002;
  localparam logic [14:0] E_RING  = 15'h0001;
  localparam logic [4:0]  B_NONE = 5'b00000, B_MODE = 5'b10000, B_L = 5'b01000;
  localparam logic [4:0]  B_R = 5'b00100, B_U = 5'b00010, B_D = 5'b00001;

  alarm_clock_controller dut (
    .clk_i(clk), .reset_i(reset), .tick_1hz_i(tick),
    .btn_mode_i(btn_mode), .btn_left_i(btn_left), .btn_right_i(btn_right),
    .btn_up_i(btn_up), .btn_down_i(btn_down), .alarm_on_i(alarm_on),
    .sec_count_i(sec_count), .min_count_i(min_count), .alarm_min_count_i(alarm_min_count),
    .hr_count_i(hr_count), .alarm_hr_count_i(alarm_hr_count),
    .sec_en_o(sec_en), .min_en_o(min_en), .hr_en_o(hr_en),
    .min_dn_o(min_dn), .hr_dn_o(hr_dn), .sec_load_o(sec_load),
    .alarm_min_en_o(alarm_min_en), .alarm_hr_en_o(alarm_hr_en),
    .alarm_min_dn_o(alarm_min_dn), .alarm_hr_dn_o(alarm_hr_dn),
    .setting_o(setting), .sel_field_o(sel_field), .blink_o(blink), .ringing_o(ringing)
  );

  assign obs = {sec_en, min_en, hr_en, min_dn, hr_dn, sec_load, alarm_min_en, alarm_hr_en,
                alarm_min_dn, alarm_hr_dn, setting, sel_field, blink, ringing};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [14:0] st(input logic [1:0] f);
    st = E_SET | {11'd0, f, 2'b00};
  endfunction

  // Drive one cycle of stimulus, queue its expected outputs, check them after the edge.
  task automatic step(input logic [4:0] b, input logic t, input logic [14:0] e, input string tag);
    logic [14:0] ex;
    string       tg;
    {btn_mode, btn_left, btn_right, btn_up, btn_down} = b;
    tick = t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    {btn_mode, btn_left, btn_right, btn_up, btn_down} = B_NONE;
    tick = 1'b0;
    ex = exp_q.pop_front();
    tg = tag_q.pop_front();
    n_tests++;
    assert (obs === ex) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tg, obs, ex);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    step(B_NONE, 1'b0, 15'h0, "reset_state");
    step(B_U, 1'b1, 15'h0, "reset_suppress");
    reset = 1'b0;

    // Cascade at 23:59:59
    hr_count = 5'd23; min_count = 6'd59; sec_count = 6'd59;
    step(B_NONE, 1'b1, E_SEC | E_MIN | E_HR, "cascade_rollover");
    step(B_NONE, 1'b0, 15'h0, "cascade_one_cycle");
    step(B_NONE, 1'b0, 15'h0, "idle");
    step(B_NONE, 1'b0, 15'h0, "idle");
    min_count = 6'd10;
    step(B_NONE, 1'b1, E_SEC | E_MIN, "cascade_min_only");
    step(B_U, 1'b0, 15'h0, "run_ignores_up");
    step(B_L, 1'b0, 15'h0, "run_ignores_left");
    step(B_NONE, 1'b0, 15'h0, "idle");
    sec_count = 6'd5;
    step(B_NONE, 1'b1, E_SEC, "cascade_sec_only");

    // Field navigation
    step(B_MODE, 1'b0, st(2'd0), "nav_enter_set");
    step(B_L, 1'b0, st(2'd3), "nav_left_wrap");
    step(B_R, 1'b0, st(2'd0), "nav_right_wrap");
    step(B_R, 1'b0, st(2'd1), "nav_right");
    step(B_U, 1'b0, st(2'd1) | E_MIN, "set_min_up");
    step(B_D, 1'b0, st(2'd1) | E_MDN, "set_min_down");
    step(B_L | B_R, 1'b0, st(2'd1), "nav_left_right_both");
    step(B_U | B_D, 1'b0, st(2'd1), "adj_up_down_both");
    step(B_MODE, 1'b0, E_LOAD, "nav_exit_load");
    step(B_NONE, 1'b0, 15'h0, "load_one_cycle");

    // Setting in SET_ALARM_MIN / SET_ALARM_HR
    step(B_MODE, 1'b0, st(2'd0), "enter_set");
    step(B_L, 1'b0, st(2'd3), "to_alarm_min");
    step(B_U, 1'b0, st(2'd3) | E_AMEN, "alarm_min_up");
    step(B_D, 1'b0, st(2'd3) | E_AMDN, "alarm_min_down");
    step(B_NONE, 1'b1, st(2'd3) | E_BLINK, "set_tick_blink");
    for (int i = 0; i < 3; i++) step(B_NONE, 1'b0, st(2'd3) | E_BLINK, "blink_hold");
    step(B_NONE, 1'b1, st(2'd3), "set_tick_blink_back");
    step(B_L, 1'b0, st(2'd2), "to_alarm_hr");
    step(B_U, 1'b0, st(2'd2) | E_AHEN, "alarm_hr_up");
    step(B_D, 1'b0, st(2'd2) | E_AHDN, "alarm_hr_down");
    step(B_R, 1'b0, st(2'd3), "nav_right_to3");
    step(B_R, 1'b0, st(2'd0), "nav_right_3_wraps");
    step(B_D, 1'b0, st(2'd0) | E_HDN, "time_hr_down");
    step(B_L, 1'b0, st(2'd3), "nav_left");
    step(B_L, 1'b0, st(2'd2), "nav_left_to2");

    // Reset mid-SET with btn_up in the same cycle
    reset = 1'b1;
    step(B_U, 1'b0, 15'h0, "reset_mid_set");
    reset = 1'b0;
    step(B_NONE, 1'b0, 15'h0, "after_reset_idle");
    step(B_U, 1'b0, 15'h0, "after_reset_run");
    step(B_MODE, 1'b0, st(2'd0), "after_reset_enter");
    step(B_MODE, 1'b0, E_LOAD, "after_reset_exit");

    // Alarm ring and dismiss at 07:30
    alarm_on = 1'b1; alarm_hr_count = 5'd7; alarm_min_count = 6'd30;
    hr_count = 5'd7; min_count = 6'd29; sec_count = 6'd59;
    step(B_NONE, 1'b1, E_SEC | E_MIN, "pre_alarm_tick");
    min_count = 6'd30; sec_count = 6'd0;
    step(B_NONE, 1'b0, E_RING, "alarm_ring");
    step(B_NONE, 1'b0, E_RING, "alarm_ring_hold");
    step(B_MODE, 1'b0, 15'h0, "alarm_dismiss");
    step(B_NONE, 1'b0, 15'h0, "no_retrigger_same_second");
    step(B_U, 1'b0, 15'h0, "still_run");

    // Alarm timeout after 60 ticks
    sec_count = 6'd1;
    step(B_NONE, 1'b0, 15'h0, "match_low");
    sec_count = 6'd0;
    step(B_NONE, 1'b0, E_RING, "alarm_ring_again");
    for (int i = 0; i < 60; i++) begin
      sec_count = 6'(i);
      step(B_NONE, 1'b1, E_SEC | ((i == 59) ? E_MIN : 15'h0) | ((i < 59) ? E_RING : 15'h0),
           "timeout_tick");
      if (i == 59) begin
        min_count = 6'd31;
        sec_count = 6'd0;
      end else begin
        sec_count = 6'(i + 1);
      end
      for (int k = 0; k < 3; k++)
        step(B_NONE, 1'b0, (i < 59) ? E_RING : 15'h0, "timeout_idle");
    end

    // alarm_on falling clears ringing
    min_count = 6'd30; sec_count = 6'd1;
    step(B_NONE, 1'b0, 15'h0, "match_low2");
    sec_count = 6'd0;
    step(B_NONE, 1'b0, E_RING, "alarm_ring_third");
    alarm_on = 1'b0;
    step(B_NONE, 1'b0, 15'h0, "alarm_off_clears");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
